// File: rtl/barrier_field_if.sv
// Stream and display signals between the barrier generator side and the field.
interface barrier_field_if #(
   parameter int ROWS = 8
);
   logic                start;
   logic [7:0]          row_in;
   logic [7:0]          player;
   logic [8*ROWS-1:0]   green;
   logic                gg;
   logic [7:0]          score;
   logic                running;

   modport master (
      output start, row_in, player,
      input  green, gg, score, running
   );

   modport slave (
      input  start, row_in, player,
      output green, gg, score, running
   );
endinterface

// File: rtl/barrier_field.sv
// Barrier field: scrolls captured top-row patterns down the green plane,
// detects collision with the player cart and keeps the dodged-row score.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; field and sampling counter held
// RUN   | sampling counter free-runs; scroll on tick, check collision
// OVER  | game over; everything frozen until reset
module barrier_field #(
   parameter int WIDTH = 2,
   parameter int ROWS  = 8
) (
   input logic             clk,
   input logic             reset,
   barrier_field_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   state_t              state;
   logic [WIDTH-1:0]    cnt;
   logic [8*ROWS-1:0]   field;
   logic [7:0]          score_q;
   logic                gg_q;
   logic                running_q;

   logic [7:0]          bottom;
   logic                hit;
   logic                tick;

   // Bottom row is compared against the live player input; tick is the
   // first cycle of each sampling period.
   assign bottom = field[8*ROWS-1 -: 8];
   assign hit    = |(bottom & bus.player);
   assign tick   = (cnt == '0);

   // Sequencer, field shift register and score; collision wins over scroll.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         field     <= '0;
         score_q   <= '0;
         gg_q      <= 1'b0;
         running_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= RUN;
                  running_q <= 1'b1;
               end
            end
            RUN: begin
               cnt <= cnt + WIDTH'(1);
               if (hit) begin
                  state     <= OVER;
                  gg_q      <= 1'b1;
                  running_q <= 1'b0;
               end else if (tick) begin
                  field <= {field[8*(ROWS-1)-1:0], bus.row_in};
                  if (bottom != 8'h00 && score_q != 8'hFF)
                     score_q <= score_q + 8'd1;
               end
            end
            OVER: state <= OVER;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.green   = field;
   assign bus.gg      = gg_q;
   assign bus.score   = score_q;
   assign bus.running = running_q;
endmodule

// File: tb/tb_barrier_field.sv
// Randomized and directed checks of barrier_field against a row-list model.
module tb_barrier_field;
   localparam int WIDTH  = 2;
   localparam int ROWS   = 8;
   localparam int PERIOD = 1 << WIDTH;

   logic clk;
   logic reset;

   barrier_field_if #(.ROWS(ROWS)) bus ();

   barrier_field #(.WIDTH(WIDTH), .ROWS(ROWS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: list of rows, score, game flags and position in period.
   logic [7:0] m_row [ROWS];
   int         m_score;
   bit         m_running;
   bit         m_gg;
   int         m_phase;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [8*ROWS-1:0] exp_green();
      logic [8*ROWS-1:0] v;
      for (int r = 0; r < ROWS; r++) v[8*r +: 8] = m_row[r];
      return v;
   endfunction

   task automatic model_step();
      bit hit;
      if (reset) begin
         for (int r = 0; r < ROWS; r++) m_row[r] = 8'h00;
         m_score = 0; m_running = 0; m_gg = 0; m_phase = 0;
      end else if (m_gg) begin
         // frozen
      end else if (!m_running) begin
         if (bus.start) m_running = 1;
      end else begin
         hit = |(m_row[ROWS-1] & bus.player);
         if (hit) begin
            m_gg = 1;
            m_running = 0;
         end else if (m_phase == 0) begin
            if (m_row[ROWS-1] != 8'h00) m_score = (m_score < 255) ? m_score + 1 : 255;
            for (int i = ROWS-1; i > 0; i--) m_row[i] = m_row[i-1];
            m_row[0] = bus.row_in;
         end
         m_phase = (m_phase + 1) % PERIOD;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("green", 64'(bus.green), 64'(exp_green()));
      chk("gg", 64'(bus.gg), 64'(m_gg));
      chk("score", 64'(bus.score), 64'(m_score));
      chk("running", 64'(bus.running), 64'(m_running));
   endtask

   task automatic do_reset();
      reset = 1'b1; bus.start = 1'b0;
      cycle();
      reset = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      cycle();
      bus.start = 1'b0;
   endtask

   int         ticks;
   int         saved_score;
   int         guard;
   logic [7:0] pat;

   initial begin
      reset = 1'b1; bus.start = 1'b0; bus.row_in = 8'h00; bus.player = 8'h00;
      for (int r = 0; r < ROWS; r++) m_row[r] = 8'h00;
      m_score = 0; m_running = 0; m_gg = 0; m_phase = 0;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_green", 64'(bus.green), 64'h0);
      chk("rst_gg", 64'(bus.gg), 64'h0);
      chk("rst_score", 64'(bus.score), 64'h0);
      chk("rst_running", 64'(bus.running), 64'h0);

      // Fill the field with a held pattern.
      bus.row_in = 8'h81; bus.player = 8'h18;
      do_start();
      chk("run_entry", 64'(bus.running), 64'h1);
      cycle();
      chk("row0_first", 64'(bus.green[7:0]), 64'h81);
      repeat (28) cycle();
      chk("field_full", 64'(bus.green), {8{8'h81}});
      chk("score_before", 64'(bus.score), 64'h0);
      repeat (4) cycle();
      chk("score_first", 64'(bus.score), 64'h1);
      chk("gg_first", 64'(bus.gg), 64'h0);

      // Collision freezes everything.
      bus.player = 8'h01;
      cycle();
      chk("hit_gg", 64'(bus.gg), 64'h1);
      chk("hit_running", 64'(bus.running), 64'h0);
      bus.player = 8'h00;
      for (int i = 0; i < 20; i++) begin
         bus.row_in = 8'($urandom);
         bus.start = 1'($urandom);
         cycle();
      end
      bus.start = 1'b0;
      chk("frozen_green", 64'(bus.green), {8{8'h81}});
      chk("frozen_score", 64'(bus.score), 64'h1);
      chk("frozen_gg", 64'(bus.gg), 64'h1);

      // Hit on a tick cycle: no capture, no score.
      do_reset();
      bus.row_in = 8'h81; bus.player = 8'h18;
      do_start();
      repeat (40) cycle();
      guard = 0;
      while (m_phase != 0 && guard < PERIOD) begin
         cycle();
         guard++;
      end
      chk("tick_align", 64'(m_phase), 64'h0);
      saved_score = m_score;
      bus.player = 8'h01; bus.row_in = 8'hFF;
      cycle();
      chk("tickhit_gg", 64'(bus.gg), 64'h1);
      chk("tickhit_row0", 64'(bus.green[7:0]), 64'h81);
      chk("tickhit_score", 64'(bus.score), 64'(saved_score));

      // Alternating empty and populated rows.
      do_reset();
      bus.player = 8'h80; bus.row_in = 8'h00;
      do_start();
      ticks = 0; guard = 0;
      while (ticks < 64 && guard < 400) begin
         if (m_running && m_phase == 0) begin
            bus.row_in = (ticks % 2 == 1) ? 8'h3C : 8'h00;
            ticks++;
         end
         cycle();
         guard++;
      end
      chk("alt_ticks", 64'(ticks), 64'd64);
      chk("alt_score", 64'(bus.score), 64'd28);
      chk("alt_gg", 64'(bus.gg), 64'h0);

      // Saturation.
      do_reset();
      bus.player = 8'h80; bus.row_in = 8'h01;
      do_start();
      repeat (300 * PERIOD) cycle();
      chk("sat_score", 64'(bus.score), 64'd255);
      repeat (3 * PERIOD) cycle();
      chk("sat_hold", 64'(bus.score), 64'd255);

      // Reset in mid-game.
      do_reset();
      bus.player = 8'h80;
      do_start();
      guard = 0;
      while (m_score < 5 && guard < 500) begin
         pat = 8'($urandom_range(1, 127));
         bus.row_in = pat;
         cycle();
         guard++;
      end
      chk("mid_score5", 64'(bus.score), 64'd5);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("mid_green", 64'(bus.green), 64'h0);
      chk("mid_score", 64'(bus.score), 64'h0);
      chk("mid_gg", 64'(bus.gg), 64'h0);
      chk("mid_running", 64'(bus.running), 64'h0);
      repeat (10) cycle();
      chk("mid_idle", 64'(bus.running), 64'h0);
      chk("mid_idle_green", 64'(bus.green), 64'h0);
      do_start();
      chk("mid_resume", 64'(bus.running), 64'h1);

      // Random play.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0) || (m_gg && $urandom_range(0, 15) == 0);
         bus.start = ($urandom_range(0, 3) == 0);
         bus.row_in = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
         case ($urandom_range(0, 9))
            0:       bus.player = 8'h00;
            1:       bus.player = 8'($urandom);
            default: bus.player = 8'h01 << $urandom_range(0, 7);
         endcase
         cycle();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
